// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage with the HI/LO pair built in.
// Multiply is shift-add on magnitudes, divide is restoring; signs are fixed up in FIN.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Handshake: start is taken only when busy=0 (IDLE) and cancel=0; busy stays
    // high until the result is written, and done pulses for exactly one cycle after.
    logic accept;
    logic writeback;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !cancel) state_d = S_RUN;
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = 1'b0;
        accept    = 1'b0;
        writeback = 1'b0;
        case (state_q)
            S_IDLE:  accept = start && !cancel;
            S_RUN:   busy = 1'b1;
            S_FIN: begin
                busy      = 1'b1;
                writeback = !cancel;
            end
            default: busy = 1'b0;
        endcase
    end

    // Operand conditioning
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = signed_en & a[WIDTH-1];
        b_neg = signed_en & b[WIDTH-1];
        a_mag = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // One iteration of each algorithm; acc holds {upper, lower} halves
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, divisor_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, divisor_q});
        div_diff  = div_shift[WIDTH-1:0] - divisor_q;
        div_rem   = div_fits ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_fits};
    end

    // Sign correction and special cases. The most-negative / -1 overflow falls out
    // naturally: magnitudes give quotient 2**(WIDTH-1), remainder 0, no negation.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod   = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        quot_s = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_s  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                           : acc_q[2*WIDTH-1:WIDTH];
        if (!op_q) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (div_zero_q) begin
            res_hi = a_raw_q;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = rem_s;
            res_lo = quot_s;
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        a_raw_d    = a_raw_q;
        divisor_d  = divisor_q;
        acc_d      = acc_q;
        if (accept) begin
            cnt_d      = '0;
            op_d       = op;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            div_zero_d = (b == '0);
            a_raw_d    = a;
            divisor_d  = b_mag;
            acc_d      = {{WIDTH{1'b0}}, a_mag};
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = op_q ? div_next : mul_next;
        end

        // A direct write always wins over the result for its own half
        hi_d = hilo_we[1] ? hilo_wdata : (writeback ? res_hi : hi_q);
        lo_d = hilo_we[0] ? hilo_wdata : (writeback ? res_lo : lo_q);
        done_d = writeback;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            op_q       <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            divisor_q  <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            divisor_q  <= divisor_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random operations, with results
// predicted by plain integer arithmetic and checked by a done-triggered monitor.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic         signed_en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic [1:0]   hilo_we;
    logic [W-1:0] hilo_wdata;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   model_hi = '0;
    logic [W-1:0]   model_lo = '0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .signed_en  (signed_en),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} straight from integer arithmetic semantics
    function automatic logic [63:0] ref_model(input logic o, input logic s,
                                              input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        int sx, sy, q, r;
        logic [63:0] ux, uy;
        if (!o) begin
            if (s) begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            ux = {32'h0, x};
            uy = {32'h0, y};
            return ux * uy;
        end
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
            sx = x;
            sy = y;
            q = sx / sy;
            r = sx % sy;
            return {r, q};
        end
        return {x % y, x / y};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [63:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("result", {hi, lo}, e);
            end
        end
    end

    // Called at a negedge with the unit idle; returns at the negedge after done.
    task automatic do_op(input logic o, input logic s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [1:0] we_fin,
                         input logic [W-1:0] wd, input bit poke);
        logic [63:0] e;
        int cyc;
        e = ref_model(o, s, x, y);
        if (we_fin[1]) e[63:32] = wd;
        if (we_fin[0]) e[31:0]  = wd;
        exp_q.push_back(e);
        model_hi = e[63:32];
        model_lo = e[31:0];
        op = o;
        signed_en = s;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            start = (poke && cyc == 5);
            if (poke && cyc == 5) op = ~o;
            if (cyc == W) begin
                hilo_we = we_fin;
                hilo_wdata = wd;
            end else begin
                hilo_we = 2'b00;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        hilo_we = 2'b00;
        check("busy_cycles", cyc, W + 1);
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    logic [W-1:0] specials[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [W-1:0] wd;
        rst = 1'b0;
        start = 1'b1;
        op = 1'b0;
        signed_en = 1'b0;
        a = 32'h5;
        b = 32'h7;
        cancel = 1'b0;
        hilo_we = 2'b00;
        hilo_wdata = '0;

        // Reset held with start asserted: nothing launches
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
        end
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_done", done, 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Directed operations
        do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, '0, 1'b0);
        do_op(1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000, 2'b00, '0, 1'b0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 2'b00, '0, 1'b0);

        // Cancel mid-RUN: no writeback, no done, then an immediate new op
        op = 1'b0;
        signed_en = 1'b0;
        a = 32'hABCD_0123;
        b = 32'h0000_1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        check("cancel_done", done, 0);
        check("cancel_hilo", {hi, lo}, {model_hi, model_lo});
        do_op(1'b1, 1'b0, 32'd1000, 32'd7, 2'b00, '0, 1'b0);

        // Direct LO write at the FIN edge, plus a start pulse while busy
        do_op(1'b0, 1'b1, 32'd3, 32'hFFFF_FFFC, 2'b01, 32'hDEAD_BEEF, 1'b1);

        // Idle direct write of HI only
        hilo_we = 2'b10;
        hilo_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hilo_we = 2'b00;
        model_hi = 32'hCAFE_F00D;
        check("direct_write", {hi, lo}, {model_hi, model_lo});

        // Reset pulse mid-RUN
        op = 1'b1;
        signed_en = 1'b1;
        a = 32'h0000_1000;
        b = 32'h0000_0003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_hi = '0;
        model_lo = '0;
        check("midrst_hilo", {hi, lo}, 64'h0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);

        // Random operations, some with a direct write landing at FIN
        for (int i = 0; i < 40; i++) begin
            wd = $urandom;
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  wd, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with the HI/LO register pair built in.
- Successor to the fixed 32-bit divider plus separate hilo register in the execute stage; adds iterative multiply, a WIDTH parameter, cancel on pipeline flush, and defined divide-by-zero and overflow results.
- Sits in the execute stage. busy drives the hazard unit's stall; hi/lo feed the mfhi/mflo result mux.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-low reset
start  in  1  launch an operation; sampled only in IDLE
op  in  1  0 = multiply, 1 = divide
signed_en  in  1  1 = signed operands, 0 = unsigned
a  in  WIDTH  multiplicand / dividend
b  in  WIDTH  multiplier / divisor
cancel  in  1  abort the in-flight operation (pipeline flush)
hilo_we  in  2  direct write enables: [1] = HI, [0] = LO (mthi/mtlo)
hilo_wdata  in  WIDTH  direct write data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight; stall request
done  out  1  one-cycle pulse; hi/lo hold the new result while high

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal registers=0. Reset overrides all other inputs and aborts any operation.
- States: IDLE, RUN, FIN. busy=1 exactly while in RUN or FIN. done is registered, default 0.
- IDLE:
  - start=1 and cancel=0 → latch op and signed_en. Latch |a| and |b| when signed_en=1, else a and b. Record the result signs. Counter=0. Go to RUN.
  - start=1 and cancel=1 in the same cycle → ignored; stay IDLE.
- RUN: one iteration per cycle for WIDTH cycles, counter 0..WIDTH-1. Go to FIN when counter==WIDTH-1.
  - Multiply: shift-add on unsigned magnitudes; 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIN: apply sign correction. Write hi/lo, set done=1 for the next cycle, go to IDLE.
- Latency: start sampled at edge E0; RUN spans edges E1..E_WIDTH; FIN writeback at edge E_(WIDTH+1). For WIDTH=32, done=1 in the cycle after the 33rd edge following the start edge.
- start while busy=1 → ignored; no queuing.
- Multiply result: {hi,lo} = full 2*WIDTH product. Two's complement when signed_en=1 and the operand signs differ.
- Divide result: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
- Divide by zero (b=0), either mode: lo = all ones, hi = a unchanged. Still takes the full latency.
- Signed overflow (a = most negative, b = -1): lo = a, hi = 0.
- cancel=1 in RUN or FIN → IDLE at the next edge. hi/lo unchanged, done stays 0, busy=0 from the next cycle. Cancel during FIN suppresses the writeback.
- Direct writes (hilo_we) are accepted in any state.
  - HI takes hilo_wdata when hilo_we[1]=1; LO when hilo_we[0]=1.
  - At the FIN edge, a directly written half takes hilo_wdata; the other half takes the operation result.
  - Direct writes never set done and never cancel an operation.
- hi/lo are read combinationally from the registers, with no bypass. A same-edge direct write becomes visible the next cycle.

Test Plan:
- Unsigned multiply, a=0xFFFFFFFF, b=0x00000002, start for 1 cycle → busy high for 33 cycles; done pulse; hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide, a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same operands unsigned → lo=0x7FFFFFFC, hi=0x00000001.
- Divide by zero, a=0x12345678, b=0, signed and unsigned → lo=0xFFFFFFFF, hi=0x12345678. Signed a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start a multiply and assert cancel at RUN cycle 10 → busy=0 next cycle, no done, hi/lo retain prior values. Then start a new operation immediately → correct result after 33 cycles.
- hilo_we=2'b01 with wdata=0xDEADBEEF at the FIN edge of signed multiply 3 × -4 → lo=0xDEADBEEF, hi=0xFFFFFFFF, done=1. Also: a start pulse during busy is ignored.
- rst=0 for 1 cycle mid-RUN → hi=lo=0, busy=0, done=0 next cycle. rst=0 held while start=1 → state stays IDLE.
